// File: rtl/pixel_dispatch_pkg.sv
// Shared types and defaults for the frame scan controller.
package pixel_dispatch_pkg;

  localparam int H_RES_DEF = 800;
  localparam int V_RES_DEF = 600;
  localparam int LANES_DEF = 4;

  localparam logic [1:0] LVL0 = 2'd0;
  localparam logic [1:0] LVL1 = 2'd1;
  localparam logic [1:0] LVL2 = 2'd2;
  localparam logic [1:0] LVL3 = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/pixel_dispatch_lane_collect.sv
// Done mask plus sticky capture of the first escape count reported by each lane.
// all_done is combinational so the controller can leave WAIT on the edge that completes the mask.
module lane_collect #(
  parameter int LANES  = 4,
  parameter int ITER_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [LANES-1:0]        done,
  input  logic [LANES*ITER_W-1:0] iter,
  output logic [LANES*ITER_W-1:0] cnt,
  output logic                    all_done
);

  logic [LANES-1:0] mask;
  logic [LANES-1:0] hit;

  assign hit      = en ? (done & ~mask) : '0;
  assign all_done = en && (&(mask | hit));

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      cnt  <= '0;
    end else begin
      if (clr) mask <= '0;
      else     mask <= mask | hit;
      for (int k = 0; k < LANES; k++) begin
        if (hit[k]) cnt[k*ITER_W +: ITER_W] <= iter[k*ITER_W +: ITER_W];
      end
    end
  end

endmodule

// File: rtl/pixel_dispatch.sv
// Scans the screen in groups of LANES pixels, sequences MBT clear/start and
// serialises the returned escape counts into linear frame-buffer writes.
module pixel_dispatch
  import pixel_dispatch_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int N      = 16,
  parameter int ITER_W = 8,
  parameter int ADDR_W = 19,
  parameter int SETTLE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_req,
  input  logic [1:0]              zoom_in,
  input  logic [N-1:0]            x_min_in,
  input  logic [N-1:0]            y_max_in,
  output logic [1:0]              zoom_level,
  output logic [N-1:0]            x_min,
  output logic [N-1:0]            y_max,
  output logic [15:0]             i_x,
  output logic [15:0]             i_y,
  output logic                    rstMBT,
  output logic                    start,
  input  logic [LANES-1:0]        mbt_done,
  input  logic [LANES*ITER_W-1:0] mbt_iter,
  output logic                    fb_we,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [ITER_W-1:0]       fb_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [15:0]       LANES16    = 16'(LANES);
  localparam logic [15:0]       H_RES16    = 16'(H_RES);
  localparam logic [15:0]       X_LAST     = 16'(H_RES - LANES);
  localparam logic [15:0]       Y_LAST     = 16'(V_RES - 1);
  localparam logic [7:0]        SETTLE_LD  = 8'(SETTLE - 1);
  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(LANES);

  state_t                    state, state_nxt;
  logic [7:0]                settle_cnt;
  logic [LANE_W-1:0]         lane;
  logic [ADDR_W-1:0]         base;
  logic                      collect_clr, collect_en, all_done;
  logic [LANES*ITER_W-1:0]   lane_cnt;
  logic                      last_grp;

  assign last_grp = (i_x == X_LAST) && (i_y == Y_LAST);

  lane_collect #(
    .LANES  (LANES),
    .ITER_W (ITER_W)
  ) u_collect (
    .clk      (clk),
    .rst      (rst),
    .clr      (collect_clr),
    .en       (collect_en),
    .done     (mbt_done),
    .iter     (mbt_iter),
    .cnt      (lane_cnt),
    .all_done (all_done)
  );

  always_comb begin
    state_nxt   = state;
    rstMBT      = 1'b0;
    start       = 1'b0;
    fb_we       = 1'b0;
    frame_done  = 1'b0;
    collect_clr = 1'b0;
    collect_en  = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:   if (frame_req) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_CLEAR;
      S_CLEAR: begin
        rstMBT      = 1'b1;
        collect_clr = 1'b1;
        state_nxt   = S_SETTLE;
      end
      S_SETTLE: if (settle_cnt == 8'd0) state_nxt = S_START;
      S_START: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        collect_en = 1'b1;
        if (all_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        fb_we = 1'b1;
        if (lane == LANE_LAST) state_nxt = S_NEXT;
      end
      S_NEXT:   state_nxt = last_grp ? S_DONE : S_CLEAR;
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address and data are forced to zero outside WRITE so idle outputs stay clean.
  assign fb_addr = fb_we ? (base + ADDR_W'(lane)) : '0;
  assign fb_data = fb_we ? lane_cnt[lane*ITER_W +: ITER_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      zoom_level <= '0;
      x_min      <= '0;
      y_max      <= '0;
      i_x        <= '0;
      i_y        <= '0;
      base       <= '0;
      settle_cnt <= '0;
      lane       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          zoom_level <= zoom_in;
          x_min      <= x_min_in;
          y_max      <= y_max_in;
          i_x        <= '0;
          i_y        <= '0;
          base       <= '0;
        end
        S_CLEAR: begin
          settle_cnt <= SETTLE_LD;
          lane       <= '0;
        end
        S_SETTLE: if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        S_WRITE:  lane <= (lane == LANE_LAST) ? '0 : lane + LANE_W'(1);
        S_NEXT: begin
          base <= base + ADDR_STEP;
          if (i_x + LANES16 < H_RES16) begin
            i_x <= i_x + LANES16;
          end else begin
            i_x <= '0;
            i_y <= i_y + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
